// File: rtl/controller_poller.sv
// rtl/controller_poller.sv - serial poller for two NES-style controller ports
// Optional sticky newly-pressed flags are enabled by CONTROLLER_POLLER_PRESSED_EN.
module controller_poller #(
  parameter int unsigned TICK_DIV    = 6,
  parameter int unsigned LATCH_TICKS = 2
) (
  input  logic       clk_12_5875,
  input  logic       rst_B,
  input  logic       start,
  input  logic       controller_1_data_in_B,
  input  logic       controller_2_data_in_B,
`ifdef CONTROLLER_POLLER_PRESSED_EN
  input  logic       pressed_clear,
  output logic [7:0] pressed_1,
  output logic [7:0] pressed_2,
`endif
  output logic       controller_clk,
  output logic       controller_latch,
  output logic [7:0] buttons_1,
  output logic [7:0] buttons_2,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] TICK_LAST  = 8'(TICK_DIV - 1);
  localparam logic [3:0] LATCH_LAST = 4'(LATCH_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [3:0] lat_q, lat_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr1_q, sr1_d;
  logic [7:0] sr2_q, sr2_d;
  logic [7:0] btn1_q, btn1_d;
  logic [7:0] btn2_q, btn2_d;
  logic       cclk_q, cclk_d;
  logic       clat_q, clat_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick_end;
`ifdef CONTROLLER_POLLER_PRESSED_EN
  logic [7:0] pr1_q, pr1_d;
  logic [7:0] pr2_q, pr2_d;
`endif

  assign tick_end = (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_end ? 8'd0 : tick_q + 8'd1;
    lat_d   = lat_q;
    bit_d   = bit_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    btn1_d  = btn1_q;
    btn2_d  = btn2_q;
`ifdef CONTROLLER_POLLER_PRESSED_EN
    // Clear first so an edge landing in the same cycle still gets recorded.
    pr1_d   = pressed_clear ? 8'h00 : pr1_q;
    pr2_d   = pressed_clear ? 8'h00 : pr2_q;
`endif
    case (state_q)
      IDLE: begin
        tick_d = 8'd0;
        if (start) begin
          state_d = LATCH;
          bit_d   = 3'd0;
          lat_d   = 4'd0;
        end
      end
      LATCH: begin
        if (tick_end) begin
          if (lat_q == LATCH_LAST) state_d = LOW;
          else                     lat_d   = lat_q + 4'd1;
        end
      end
      LOW: begin
        if (tick_end) begin
          sr1_d[3'd7 - bit_q] = ~controller_1_data_in_B;
          sr2_d[3'd7 - bit_q] = ~controller_2_data_in_B;
          state_d             = HIGH;
        end
      end
      HIGH: begin
        if (tick_end) begin
          if (bit_q == 3'd7) begin
            state_d = DONE;
            btn1_d  = sr1_q;
            btn2_d  = sr2_q;
`ifdef CONTROLLER_POLLER_PRESSED_EN
            pr1_d   = pr1_d | (sr1_q & ~btn1_q);
            pr2_d   = pr2_d | (sr2_q & ~btn2_q);
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = LOW;
          end
        end
      end
      DONE: begin
        tick_d  = 8'd0;
        state_d = IDLE;
      end
      default: begin
        tick_d  = 8'd0;
        state_d = IDLE;
      end
    endcase

    // Pad-facing strobes are registered from the next state so they never glitch.
    cclk_d = (state_d != LOW);
    clat_d = (state_d == LATCH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      state_q <= IDLE;
      tick_q  <= 8'd0;
      lat_q   <= 4'd0;
      bit_q   <= 3'd0;
      sr1_q   <= 8'h00;
      sr2_q   <= 8'h00;
      btn1_q  <= 8'h00;
      btn2_q  <= 8'h00;
      cclk_q  <= 1'b1;
      clat_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CONTROLLER_POLLER_PRESSED_EN
      pr1_q   <= 8'h00;
      pr2_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      lat_q   <= lat_d;
      bit_q   <= bit_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      btn1_q  <= btn1_d;
      btn2_q  <= btn2_d;
      cclk_q  <= cclk_d;
      clat_q  <= clat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CONTROLLER_POLLER_PRESSED_EN
      pr1_q   <= pr1_d;
      pr2_q   <= pr2_d;
`endif
    end
  end

  assign controller_clk   = cclk_q;
  assign controller_latch = clat_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign buttons_1        = btn1_q;
  assign buttons_2        = btn2_q;
`ifdef CONTROLLER_POLLER_PRESSED_EN
  assign pressed_1        = pr1_q;
  assign pressed_2        = pr2_q;
`endif

endmodule

// File: tb/tb_controller_poller.sv
// tb/tb_controller_poller.sv - self-checking bench for controller_poller
// Three instances (T/LATCH = 6/2, 2/2, 1/1) polled in parallel against modelled pads.
module tb_controller_poller;

  localparam int NI   = 3;
  localparam int MAXC = 116;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       start;
  logic       cclk [NI];
  logic       clat [NI];
  logic       busy [NI];
  logic       done [NI];
  logic [7:0] b1   [NI];
  logic [7:0] b2   [NI];
`ifdef CONTROLLER_POLLER_PRESSED_EN
  logic       pclr [NI];
  logic [7:0] p1   [NI];
  logic [7:0] p2   [NI];
`endif
  logic [7:0] pad1, pad2;
  logic       disc1, disc2;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  function automatic int td_of(input int g);
    return (g == 0) ? 6 : ((g == 1) ? 2 : 1);
  endfunction

  function automatic int lt_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction

  function automatic int done_cycle(input int g);
    return (lt_of(g) + 16) * td_of(g) + 1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [7:0] sr1 = 8'h00;
    logic [7:0] sr2 = 8'h00;
    logic       d1, d2;

    controller_poller #(
      .TICK_DIV   ((g == 0) ? 6 : ((g == 1) ? 2 : 1)),
      .LATCH_TICKS((g == 2) ? 1 : 2)
    ) u_dut (
      .clk_12_5875           (clk),
      .rst_B                 (rst_b),
      .start                 (start),
      .controller_1_data_in_B(d1),
      .controller_2_data_in_B(d2),
`ifdef CONTROLLER_POLLER_PRESSED_EN
      .pressed_clear         (pclr[g]),
      .pressed_1             (p1[g]),
      .pressed_2             (p2[g]),
`endif
      .controller_clk        (cclk[g]),
      .controller_latch      (clat[g]),
      .buttons_1             (b1[g]),
      .buttons_2             (b2[g]),
      .busy                  (busy[g]),
      .done                  (done[g])
    );

    // 4021-style pad: parallel load while latched, shift on each rising clock.
    always @(posedge clat[g] or posedge cclk[g]) begin
      if (clat[g]) begin
        sr1 <= pad1;
        sr2 <= pad2;
      end else begin
        sr1 <= {sr1[6:0], 1'b0};
        sr2 <= {sr2[6:0], 1'b0};
      end
    end

    assign d1 = disc1 ? 1'b1 : ~sr1[7];
    assign d2 = disc2 ? 1'b1 : ~sr2[7];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s u%0d controller_clk", tag, g), 32'(cclk[g]), 32'd1);
      check($sformatf("%s u%0d controller_latch", tag, g), 32'(clat[g]), 32'd0);
      check($sformatf("%s u%0d busy", tag, g), 32'(busy[g]), 32'd0);
      check($sformatf("%s u%0d done", tag, g), 32'(done[g]), 32'd0);
      check($sformatf("%s u%0d buttons_1", tag, g), 32'(b1[g]), 32'h00);
      check($sformatf("%s u%0d buttons_2", tag, g), 32'(b2[g]), 32'h00);
    end
  endtask

  // One poll on all instances; cycle c is the cycle after edge c-1 (edge 0 samples start).
  task automatic run_poll(input string tag, input logic [7:0] exp1, input logic [7:0] exp2,
                          input int restart_at, input int reset_at, input logic clr_at_done);
    int   dc   [NI];
    int   dn   [NI];
    int   lows [NI];
    int   bbad [NI];
    logic prev [NI];
    for (int g = 0; g < NI; g++) begin
      dc[g] = -1; dn[g] = 0; lows[g] = 0; bbad[g] = 0; prev[g] = 1'b1;
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (done[g]) begin
          dn[g]++;
          if (dc[g] < 0) dc[g] = c;
        end
        if (prev[g] && !cclk[g]) lows[g]++;
        prev[g] = cclk[g];
        if (c <= done_cycle(g) && !busy[g]) bbad[g]++;
        if (c == done_cycle(g) + 1 && busy[g]) bbad[g]++;
      end
      start = (c == restart_at);
      if (reset_at > 0 && c == reset_at) rst_b = 1'b0;
      if (reset_at > 0 && c == reset_at + 2) rst_b = 1'b1;
`ifdef CONTROLLER_POLLER_PRESSED_EN
      for (int g = 0; g < NI; g++) pclr[g] = clr_at_done && (c == done_cycle(g) - 1);
`endif
    end
    if (reset_at == 0) begin
      for (int g = 0; g < NI; g++) begin
        check($sformatf("%s u%0d done count", tag, g), 32'(dn[g]), 32'd1);
        check($sformatf("%s u%0d done cycle", tag, g), 32'(dc[g]), 32'(done_cycle(g)));
        check($sformatf("%s u%0d clk low pulses", tag, g), 32'(lows[g]), 32'd8);
        check($sformatf("%s u%0d busy window errors", tag, g), 32'(bbad[g]), 32'd0);
        check($sformatf("%s u%0d buttons_1", tag, g), 32'(b1[g]), 32'(exp1));
        check($sformatf("%s u%0d buttons_2", tag, g), 32'(b2[g]), 32'(exp2));
      end
    end else begin
      for (int g = 0; g < NI; g++)
        if (done_cycle(g) > reset_at)
          check($sformatf("%s u%0d done count", tag, g), 32'(dn[g]), 32'd0);
      check_idle(tag);
    end
  endtask

  typedef struct {
    logic [7:0] pad1;
    logic [7:0] pad2;
    logic       disc1;
    logic       disc2;
    int         restart_at;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h89, 8'h26, 1'b0, 1'b0, 0,  8'h89, 8'h26};
    vecs[1] = '{8'hFF, 8'h3C, 1'b1, 1'b0, 0,  8'h00, 8'h3C};
    vecs[2] = '{8'h5A, 8'hA5, 1'b1, 1'b1, 0,  8'h00, 8'h00};
    vecs[3] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 10, 8'hA5, 8'h5A};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b0, 0,  8'h80, 8'h01};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 10, 8'hFF, 8'hFF};

    rst_b = 1'b0; start = 1'b0;
    pad1 = 8'h00; pad2 = 8'h00; disc1 = 1'b0; disc2 = 1'b0;
`ifdef CONTROLLER_POLLER_PRESSED_EN
    for (int g = 0; g < NI; g++) pclr[g] = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      pad1 = vecs[i].pad1; pad2 = vecs[i].pad2;
      disc1 = vecs[i].disc1; disc2 = vecs[i].disc2;
      run_poll($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp2, vecs[i].restart_at, 0, 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      pad1  = 8'($urandom_range(0, 255));
      pad2  = 8'($urandom_range(0, 255));
      disc1 = ($urandom_range(0, 3) == 0);
      disc2 = ($urandom_range(0, 3) == 0);
      run_poll($sformatf("rand%0d", i), disc1 ? 8'h00 : pad1, disc2 ? 8'h00 : pad2, 0, 0, 1'b0);
    end

    pad1 = 8'h89; pad2 = 8'h26; disc1 = 1'b0; disc2 = 1'b0;
    run_poll("abort", 8'h00, 8'h00, 0, 20, 1'b0);
    run_poll("after_abort", 8'h89, 8'h26, 0, 0, 1'b0);

`ifdef CONTROLLER_POLLER_PRESSED_EN
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    pad2 = 8'h00;
    pad1 = 8'h01;
    run_poll("press_a", 8'h01, 8'h00, 0, 0, 1'b0);
    for (int g = 0; g < NI; g++) check($sformatf("press_a u%0d pressed_1", g), 32'(p1[g]), 32'h01);
    pad1 = 8'h81;
    run_poll("press_b", 8'h81, 8'h00, 0, 0, 1'b0);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("press_b u%0d pressed_1", g), 32'(p1[g]), 32'h81);
      check($sformatf("press_b u%0d pressed_2", g), 32'(p2[g]), 32'h00);
    end
    pad1 = 8'h01;
    run_poll("press_c", 8'h01, 8'h00, 0, 0, 1'b0);
    pad1 = 8'h81;
    run_poll("press_clr", 8'h81, 8'h00, 0, 0, 1'b1);
    for (int g = 0; g < NI; g++) check($sformatf("press_clr u%0d pressed_1", g), 32'(p1[g]), 32'h80);
    @(negedge clk);
    for (int g = 0; g < NI; g++) pclr[g] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) pclr[g] = 1'b0;
    for (int g = 0; g < NI; g++) check($sformatf("clear u%0d pressed_1", g), 32'(p1[g]), 32'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
